// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: status codes, special register/icode values, widths.
// Also holds the write-back status FSM encoding and the bubble-to-AOK mapping.
package y86_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned NREG = 15;

  localparam logic [3:0] SAOK = 4'h1;
  localparam logic [3:0] SHLT = 4'h2;
  localparam logic [3:0] SADR = 4'h3;
  localparam logic [3:0] SINS = 4'h4;
  localparam logic [3:0] SBUB = 4'h5;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] INOP  = 4'h1;

  typedef enum logic {StRun, StStop} wb_state_e;

  // A bubble in W behaves like a normal, harmless instruction.
  function automatic logic [3:0] eff_stat(input logic [3:0] stat);
    return (stat == SBUB) ? SAOK : stat;
  endfunction

endpackage

// File: rtl/wback_regfile_if.sv
// W-stage inputs, decode read ports and committed status of the write-back block.
// The master side is the pipeline core; the slave side is wback_regfile.
interface wback_regfile_if #(
  parameter int unsigned XLEN = 64
);

  logic [3:0]      W_stat;
  logic [3:0]      W_icode;
  logic [XLEN-1:0] W_valE;
  logic [XLEN-1:0] W_valM;
  logic [3:0]      W_dstE;
  logic [3:0]      W_dstM;
  logic [3:0]      d_srcA;
  logic [3:0]      d_srcB;
  logic [XLEN-1:0] d_rvalA;
  logic [XLEN-1:0] d_rvalB;
  logic [3:0]      Stat;
  logic            halted;
  logic [XLEN-1:0] retired;

  modport master (
    output W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM, d_srcA, d_srcB,
    input  d_rvalA, d_rvalB, Stat, halted, retired
  );

  modport slave (
    input  W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM, d_srcA, d_srcB,
    output d_rvalA, d_rvalB, Stat, halted, retired
  );

endinterface

// File: rtl/regfile15.sv
// 15 x XLEN architectural register array: two write ports with M priority,
// two combinational read ports returning zero for RNONE, asynchronous clear.
module regfile15 #(
  parameter int unsigned NREG = 15,
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [3:0]      dst_e,
  input  logic [XLEN-1:0] val_e,
  input  logic [3:0]      dst_m,
  input  logic [XLEN-1:0] val_m,
  input  logic [3:0]      src_a,
  input  logic [3:0]      src_b,
  output logic [XLEN-1:0] rval_a,
  output logic [XLEN-1:0] rval_b
);

  logic [XLEN-1:0] regs_q [NREG];

  // Index RNONE never matches an entry, so it never writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (we) begin
      for (int i = 0; i < NREG; i++) begin
        if (dst_m == 4'(i)) begin
          regs_q[i] <= val_m;
        end else if (dst_e == 4'(i)) begin
          regs_q[i] <= val_e;
        end
      end
    end
  end

  always_comb begin
    rval_a = '0;
    rval_b = '0;
    if (src_a != y86_pkg::RNONE) rval_a = regs_q[src_a];
    if (src_b != y86_pkg::RNONE) rval_b = regs_q[src_b];
  end

endmodule

// File: rtl/wback_regfile.sv
// Write-back stage: commits valE/valM into the register file, keeps the sticky
// processor status (RUN -> STOP on any fault, left only by reset) and the retire count.
module wback_regfile #(
  parameter int unsigned NREG = 15,
  parameter int unsigned XLEN = 64
) (
  input logic            clk,
  input logic            rst_n,
  wback_regfile_if.slave bus
);

  import y86_pkg::*;

  wb_state_e       state_q;
  logic [3:0]      stat_q;
  logic            halted_q;
  logic [XLEN-1:0] retired_q;

  logic [3:0] w_stat;
  logic       commit;
  logic       halt_now;
  logic       count;

  always_comb begin
    w_stat   = eff_stat(bus.W_stat);
    commit   = (w_stat == SAOK) && (state_q == StRun);
    halt_now = (w_stat != SAOK) && (state_q == StRun);
    // The halting HLT retires; ADR/INS faults do not.
    count    = (commit || (halt_now && (w_stat == SHLT))) && (bus.W_icode != INOP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StRun;
      stat_q    <= SAOK;
      halted_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      if (count) retired_q <= retired_q + 1'b1;
      case (state_q)
        StRun: begin
          if (halt_now) begin
            state_q  <= StStop;
            stat_q   <= w_stat;
            halted_q <= 1'b1;
          end
        end
        StStop: begin
          state_q <= StStop;
        end
      endcase
    end
  end

  regfile15 #(
    .NREG(NREG),
    .XLEN(XLEN)
  ) u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (commit),
    .dst_e (bus.W_dstE),
    .val_e (bus.W_valE),
    .dst_m (bus.W_dstM),
    .val_m (bus.W_valM),
    .src_a (bus.d_srcA),
    .src_b (bus.d_srcB),
    .rval_a(bus.d_rvalA),
    .rval_b(bus.d_rvalB)
  );

  assign bus.Stat    = stat_q;
  assign bus.halted  = halted_q;
  assign bus.retired = retired_q;

endmodule

// File: tb/tb_wback_regfile.sv
// Bench for wback_regfile: directed vector table, hand-written halt/fault/reset
// sequences, then random W-stage traffic compared against a behavioural model.
module tb_wback_regfile;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #20 clk = ~clk;

  wback_regfile_if #(.XLEN(64)) bus();

  wback_regfile #(
    .NREG(15),
    .XLEN(64)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Architectural model
  logic [63:0] m_reg [15];
  logic [3:0]  m_stat;
  logic        m_halted;
  logic [63:0] m_retired;

  typedef struct {
    logic [3:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  de;
    logic [3:0]  dm;
    logic [63:0] ve;
    logic [63:0] vm;
    logic [3:0]  sa;
    logic [3:0]  sb;
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] eret;
    logic [3:0]  estat;
    logic        ehalt;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] m_read(input logic [3:0] idx);
    return (idx == 4'hF) ? 64'h0 : m_reg[idx];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 15; i++) m_reg[i] = 64'h0;
    m_stat    = 4'h1;
    m_halted  = 1'b0;
    m_retired = 64'h0;
  endtask

  task automatic m_step(input logic [3:0] stat, input logic [3:0] icode,
                        input logic [3:0] de, input logic [3:0] dm,
                        input logic [63:0] ve, input logic [63:0] vm);
    logic [3:0] ws;
    ws = (stat == 4'h5) ? 4'h1 : stat;
    if (m_halted) return;
    if (ws == 4'h1) begin
      if (de != 4'hF) m_reg[de] = ve;
      if (dm != 4'hF) m_reg[dm] = vm;
      if (icode != 4'h1) m_retired = m_retired + 64'd1;
    end else begin
      if (ws == 4'h2 && icode != 4'h1) m_retired = m_retired + 64'd1;
      m_stat   = ws;
      m_halted = 1'b1;
    end
  endtask

  task automatic drive(input logic [3:0] stat, input logic [3:0] icode,
                       input logic [3:0] de, input logic [3:0] dm,
                       input logic [63:0] ve, input logic [63:0] vm,
                       input logic [3:0] sa, input logic [3:0] sb);
    bus.W_stat  = stat;
    bus.W_icode = icode;
    bus.W_dstE  = de;
    bus.W_dstM  = dm;
    bus.W_valE  = ve;
    bus.W_valM  = vm;
    bus.d_srcA  = sa;
    bus.d_srcB  = sb;
  endtask

  // One W instruction: drive on negedge, reads before the edge must not see it,
  // commit on posedge, leave sampling point #1 after the edge.
  task automatic cycle(input logic [3:0] stat, input logic [3:0] icode,
                       input logic [3:0] de, input logic [3:0] dm,
                       input logic [63:0] ve, input logic [63:0] vm,
                       input logic [3:0] sa, input logic [3:0] sb);
    @(negedge clk);
    drive(stat, icode, de, dm, ve, vm, sa, sb);
    #1;
    chk("pre_edge_rvalA", bus.d_rvalA, m_read(sa));
    chk("pre_edge_rvalB", bus.d_rvalB, m_read(sb));
    @(posedge clk);
    m_step(stat, icode, de, dm, ve, vm);
    #1;
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < 16; i++) begin
      bus.d_srcA = 4'(i);
      bus.d_srcB = 4'(15 - i);
      #1;
      chk({tag, "_rvalA"}, bus.d_rvalA, m_read(4'(i)));
      chk({tag, "_rvalB"}, bus.d_rvalB, m_read(4'(15 - i)));
    end
  endtask

  // Mid-cycle async reset with a pending AOK write that must be ignored.
  task automatic do_reset(input string tag);
    @(negedge clk);
    drive(4'h1, 4'h3, 4'h2, 4'h0, 64'hFFFF, 64'hEEEE, 4'h0, 4'h2);
    @(posedge clk);
    #7;
    rst_n = 1'b0;
    #1;
    m_reset();
    chk({tag, "_rst_stat"}, {60'h0, bus.Stat}, 64'h1);
    chk({tag, "_rst_halted"}, {63'h0, bus.halted}, 64'h0);
    chk({tag, "_rst_retired"}, bus.retired, 64'h0);
    @(posedge clk);
    #1;
    check_all_regs({tag, "_rst"});
    @(negedge clk);
    drive(4'h5, 4'h1, 4'hF, 4'hF, 64'h0, 64'h0, 4'hF, 4'hF);
    rst_n = 1'b1;
  endtask

  initial begin
    int halt_age;
    logic [3:0] rs;
    int r;

    drive(4'h5, 4'h1, 4'hF, 4'hF, 64'h0, 64'h0, 4'hF, 4'hF);
    m_reset();
    do_reset("init");

    //          stat  icode de    dm    ve          vm     sa    sb    ea          eb     ret st hlt
    tbl[0] = '{4'h1, 4'h6, 4'h0, 4'h3, 64'h11,     64'h22, 4'h0, 4'h3, 64'h11,     64'h22, 64'd1, 4'h1, 1'b0};
    tbl[1] = '{4'h1, 4'h2, 4'h4, 4'h4, 64'hAA,     64'hBB, 4'h4, 4'h0, 64'hBB,     64'h11, 64'd2, 4'h1, 1'b0};
    tbl[2] = '{4'h5, 4'h1, 4'hF, 4'hF, 64'h55,     64'h66, 4'h4, 4'hF, 64'hBB,     64'h0,  64'd2, 4'h1, 1'b0};
    tbl[3] = '{4'h1, 4'h1, 4'hF, 4'hF, 64'h0,      64'h0,  4'hF, 4'h3, 64'h0,      64'h22, 64'd2, 4'h1, 1'b0};
    tbl[4] = '{4'h1, 4'h3, 4'hE, 4'hF, 64'hDEAD,   64'h7,  4'hE, 4'hF, 64'hDEAD,   64'h0,  64'd3, 4'h1, 1'b0};

    for (int i = 0; i < 5; i++) begin
      cycle(tbl[i].stat, tbl[i].icode, tbl[i].de, tbl[i].dm, tbl[i].ve, tbl[i].vm,
            tbl[i].sa, tbl[i].sb);
      chk($sformatf("vec%0d_rvalA", i), bus.d_rvalA, tbl[i].ea);
      chk($sformatf("vec%0d_rvalB", i), bus.d_rvalB, tbl[i].eb);
      chk($sformatf("vec%0d_retired", i), bus.retired, tbl[i].eret);
      chk($sformatf("vec%0d_stat", i), {60'h0, bus.Stat}, {60'h0, tbl[i].estat});
      chk($sformatf("vec%0d_halted", i), {63'h0, bus.halted}, {63'h0, tbl[i].ehalt});
    end

    // HLT retires once, then everything is frozen.
    cycle(4'h2, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 4'h1, 4'h0);
    chk("hlt_stat", {60'h0, bus.Stat}, 64'h2);
    chk("hlt_halted", {63'h0, bus.halted}, 64'h1);
    chk("hlt_retired", bus.retired, 64'd4);
    for (int i = 0; i < 2; i++) begin
      cycle(4'h1, 4'h3, 4'h1, 4'h0, 64'h5, 64'h5, 4'h1, 4'h0);
      chk("frozen_r1", bus.d_rvalA, 64'h0);
      chk("frozen_r0", bus.d_rvalB, 64'h11);
      chk("frozen_retired", bus.retired, 64'd4);
      chk("frozen_stat", {60'h0, bus.Stat}, 64'h2);
    end
    check_all_regs("halted");

    // ADR fault: no write, no retire, cleared by reset.
    do_reset("post_hlt");
    cycle(4'h1, 4'h3, 4'h2, 4'hF, 64'h44, 64'h0, 4'h2, 4'hF);
    chk("pre_adr_r2", bus.d_rvalA, 64'h44);
    chk("pre_adr_retired", bus.retired, 64'd1);
    cycle(4'h3, 4'h5, 4'hF, 4'h2, 64'h0, 64'h99, 4'h2, 4'hF);
    chk("adr_r2", bus.d_rvalA, 64'h44);
    chk("adr_stat", {60'h0, bus.Stat}, 64'h3);
    chk("adr_halted", {63'h0, bus.halted}, 64'h1);
    chk("adr_retired", bus.retired, 64'd1);
    do_reset("post_adr");
    chk("adr_reset_stat", {60'h0, bus.Stat}, 64'h1);

    // Random traffic against the model.
    halt_age = 0;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 85)      rs = 4'h1;
      else if (r < 93) rs = 4'h5;
      else             rs = 4'($urandom_range(2, 4));
      cycle(rs, 4'($urandom_range(0, 11)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), {$urandom, $urandom}, {$urandom, $urandom},
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      chk("rnd_stat", {60'h0, bus.Stat}, {60'h0, m_stat});
      chk("rnd_halted", {63'h0, bus.halted}, {63'h0, m_halted});
      chk("rnd_retired", bus.retired, m_retired);
      chk("rnd_rvalA", bus.d_rvalA, m_read(bus.d_srcA));
      chk("rnd_rvalB", bus.d_rvalB, m_read(bus.d_srcB));
      if (m_halted) halt_age++;
      if (halt_age > 3) begin
        check_all_regs("rnd_halted");
        do_reset("rnd");
        halt_age = 0;
      end
    end
    check_all_regs("rnd_end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
